mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_MASTERS, 2, number of requesting masters, 2..8.
- ADDR_WIDTH, 19, word address width, i.e. [ADDR_WIDTH:1].
- DATA_WIDTH, 16, data width; a multiple of 8.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with the lowest index winning.
REQ-002 Ports SHALL be, one per line (N = NUM_MASTERS, B = DATA_WIDTH/8):
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- m_addr  in  N*ADDR_WIDTH  per-master word address; master i occupies slice i.
- m_data_out  in  N*DATA_WIDTH  per-master write data.
- m_data_in  out  DATA_WIDTH  read data, broadcast to all masters.
- m_access  in  N  per-master request.
- m_ack  out  N  per-master completion.
- m_wr_en  in  N  per-master write flag.
- m_bytesel  in  N*B  per-master byte enables.
- m_lock  in  N  per-master bus lock request.
- s_addr  out  ADDR_WIDTH  shared bus address.
- s_data_out  out  DATA_WIDTH  shared bus write data.
- s_data_in  in  DATA_WIDTH  shared bus read data.
- s_access  out  1  shared bus request.
- s_ack  in  1  shared bus completion.
- s_wr_en  out  1  shared bus write flag.
- s_bytesel  out  B  shared bus byte enables.
- grant  out  $clog2(N)  index of the current owner, for debug.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and OWNED.
REQ-004 In IDLE with any m_access bit set, the arbiter SHALL register the winner into grant and enter OWNED on the next edge.
REQ-005 In IDLE with no m_access bit set, the FSM SHALL stay in IDLE and grant SHALL hold its value.
REQ-006 With RR_MODE=1, the winner SHALL be the first requester found searching upward from (last_owner+1) mod N.
REQ-007 With RR_MODE=0, the winner SHALL be the lowest-index requester.
REQ-008 In OWNED, s_addr, s_data_out, s_wr_en and s_bytesel SHALL combinationally follow slice [grant] of the master inputs.
REQ-009 In OWNED, s_access SHALL equal m_access[grant]; in IDLE, s_access SHALL be 0.
REQ-010 m_ack[grant] SHALL equal s_ack while OWNED; all other m_ack bits SHALL be 0; no ack SHALL be registered.
REQ-011 m_data_in SHALL equal s_data_in at all times.
REQ-012 The first s_access of a transaction SHALL assert on the cycle after the winning m_access is first seen in IDLE; arbitration latency is 1 cycle.
REQ-013 On s_ack in OWNED, the FSM SHALL return to IDLE on the next edge, and last_owner SHALL take the value of grant.
REQ-014 If m_access[grant] falls in OWNED before s_ack (an abort), the FSM SHALL return to IDLE on the next edge and last_owner SHALL NOT update.
REQ-015 A new request from any master, including the previous owner, SHALL be arbitrated no earlier than the cycle after the return to IDLE; back-to-back transactions therefore have at least one IDLE cycle between them.
REQ-016 Requests raised while another master is OWNED SHALL wait; masters SHALL hold their request and payload stable until acked.
REQ-017 With all N masters requesting continuously and RR_MODE=1, each master SHALL be granted exactly once in every N consecutive grants.

Reset
REQ-018 While reset=0 at a rising edge, the arbiter SHALL enter IDLE and set grant=0, last_owner=N-1 and the lock flag to 0.
REQ-019 While in reset, s_access SHALL be 0 and all m_ack bits SHALL be 0.
REQ-020 A reset asserted mid-transaction SHALL drop s_access on the following cycle; the interrupted master SHALL receive no ack.

Configuration
REQ-021 With macro MEM_ARBITER_LOCK_EN defined:
- If m_lock[grant]=1 at the s_ack edge, the FSM SHALL remain OWNED with the same grant.
- The next s_access from that master SHALL pass with no IDLE cycle.
- The lock SHALL release on the first s_ack with m_lock[grant]=0, or on an abort.
REQ-022 Without MEM_ARBITER_LOCK_EN, m_lock SHALL be ignored and the port SHALL remain present.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- N=2, RR_MODE=1; both masters request from reset -> master 0 granted first, then master 1, then master 0; each s_access rises 1 cycle after entry to IDLE.
- RR_MODE=0; master 1 requests continuously and master 0 requests at cycle 5 -> master 0 wins the arbitration after master 1's current ack.
- Master 0 reads address 0x12345 with s_data_in=0xBEEF and s_ack one cycle later -> m_ack=2'b01 and m_data_in=0xBEEF on the same cycle; s_bytesel equals master 0's bytesel.
- Master 1 drops m_access after 2 cycles in OWNED with no s_ack -> FSM returns to IDLE, no m_ack, and master 1 stays next in round-robin order.
- reset driven to 0 with s_access=1 -> s_access=0 on the next cycle, grant=0, no ack.
- With MEM_ARBITER_LOCK_EN defined; master 1 performs locked read then write while master 0 requests -> the two master 1 accesses are back-to-back, then master 0 is granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates NUM_MASTERS request/ack masters onto one shared memory bus.
// Arbitration is round-robin (RR_MODE=1) or fixed lowest-index priority
// (RR_MODE=0). The winner is registered into grant, and the owner's request
// and payload are then passed straight through to the shared bus until it is
// acked or the owner aborts.
//
// Optional feature macro: MEM_ARBITER_LOCK_EN
//   When defined, an owner that holds m_lock high at its s_ack keeps the bus
//   for its next access with no IDLE cycle. When undefined, m_lock is ignored.
//
// Ports (N = NUM_MASTERS, B = DATA_WIDTH/8):
//   clk, reset      clock, synchronous active-low reset
//   m_addr          N x word address (master i in slice i)
//   m_data_out      N x write data
//   m_data_in       read data broadcast to all masters
//   m_access        N request bits
//   m_ack           N completion bits (combinational from s_ack)
//   m_wr_en         N write flags
//   m_bytesel       N x B byte enables
//   m_lock          N bus lock requests
//   s_addr, s_data_out, s_wr_en, s_bytesel, s_access   shared bus outputs
//   s_data_in, s_ack                                    shared bus inputs
//   grant           index of the current owner (debug)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned RR_MODE     = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]          m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]          m_data_out,
    output logic [DATA_WIDTH-1:0]                      m_data_in,
    input  logic [NUM_MASTERS-1:0]                     m_access,
    output logic [NUM_MASTERS-1:0]                     m_ack,
    input  logic [NUM_MASTERS-1:0]                     m_wr_en,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]      m_bytesel,
    input  logic [NUM_MASTERS-1:0]                     m_lock,
    output logic [ADDR_WIDTH:1]                        s_addr,
    output logic [DATA_WIDTH-1:0]                      s_data_out,
    input  logic [DATA_WIDTH-1:0]                      s_data_in,
    output logic                                       s_access,
    input  logic                                       s_ack,
    output logic                                       s_wr_en,
    output logic [DATA_WIDTH/8-1:0]                    s_bytesel,
    output logic [$clog2(NUM_MASTERS)-1:0]             grant
);

    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned GRANT_WIDTH = $clog2(NUM_MASTERS);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [GRANT_WIDTH-1:0] last_owner_q, last_owner_d;
    logic [GRANT_WIDTH-1:0] winner;
    logic [GRANT_WIDTH-1:0] cand;
    logic                   found;

`ifdef MEM_ARBITER_LOCK_EN
    logic lock_q, lock_d;
`else
    logic unused_lock;
    assign unused_lock = ^m_lock;
`endif

    // Per-master payload views
    logic [ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];
    logic [BE_WIDTH-1:0]   be_a    [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_a[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        assign be_a[i]    = m_bytesel[i*BE_WIDTH +: BE_WIDTH];
    end

    // Winner search: upward from last_owner+1 (round-robin) or from 0 (fixed)
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                cand = GRANT_WIDTH'((32'(last_owner_q) + 32'd1 + k) % NUM_MASTERS);
            end else begin
                cand = GRANT_WIDTH'(k);
            end
            if (!found && m_access[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= GRANT_WIDTH'(NUM_MASTERS - 1);
`ifdef MEM_ARBITER_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
`ifdef MEM_ARBITER_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
`ifdef MEM_ARBITER_LOCK_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (|m_access) begin
                    state_d = OWNED;
                    grant_d = winner;
                end
            end
            OWNED: begin
                if (!m_access[grant_q]) begin
                    // Abort: round-robin position only advances for a
                    // completed access, which in a locked tenure already
                    // happened at an earlier ack.
                    state_d = IDLE;
`ifdef MEM_ARBITER_LOCK_EN
                    if (lock_q) begin
                        last_owner_d = grant_q;
                    end
                    lock_d = 1'b0;
`endif
                end else if (s_ack) begin
`ifdef MEM_ARBITER_LOCK_EN
                    // last_owner is committed when the tenure ends; no
                    // arbitration happens while locked, so order is unchanged.
                    if (m_lock[grant_q]) begin
                        lock_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        last_owner_d = grant_q;
                        lock_d       = 1'b0;
                    end
`else
                    state_d      = IDLE;
                    last_owner_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared bus handshake; gated by reset so nothing leaks while in reset
    always_comb begin
        s_access = 1'b0;
        m_ack    = '0;
        if (reset && (state_q == OWNED)) begin
            s_access       = m_access[grant_q];
            m_ack[grant_q] = s_ack;
        end
    end

    // Payload pass-through from the granted master
    assign s_addr     = addr_a[grant_q];
    assign s_data_out = wdata_a[grant_q];
    assign s_wr_en    = m_wr_en[grant_q];
    assign s_bytesel  = be_a[grant_q];
    assign m_data_in  = s_data_in;
    assign grant      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with two masters. One instance runs
// round-robin, a second runs fixed priority on the same stimulus; each
// scenario checks only the instance it targets. Lock behaviour is checked
// according to whether MEM_ARBITER_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned GW = $clog2(N);

    logic              clk;
    logic              reset;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_data_out;
    logic [DW-1:0]     m_data_in;
    logic [N-1:0]      m_access;
    logic [N-1:0]      m_ack;
    logic [N-1:0]      m_wr_en;
    logic [N*BW-1:0]   m_bytesel;
    logic [N-1:0]      m_lock;
    logic [AW:1]       s_addr;
    logic [DW-1:0]     s_data_out;
    logic [DW-1:0]     s_data_in;
    logic              s_access;
    logic              s_ack;
    logic              s_wr_en;
    logic [BW-1:0]     s_bytesel;
    logic [GW-1:0]     grant;

    logic [DW-1:0]     fp_unused_data_in;
    logic [N-1:0]      m_ack_fp;
    logic [AW:1]       fp_unused_addr;
    logic [DW-1:0]     fp_unused_data_out;
    logic              s_access_fp;
    logic              fp_unused_wr_en;
    logic [BW-1:0]     fp_unused_bytesel;
    logic [GW-1:0]     grant_fp;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut (
        .clk(clk), .reset(reset),
        .m_addr(m_addr), .m_data_out(m_data_out), .m_data_in(m_data_in),
        .m_access(m_access), .m_ack(m_ack), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .m_lock(m_lock),
        .s_addr(s_addr), .s_data_out(s_data_out), .s_data_in(s_data_in),
        .s_access(s_access), .s_ack(s_ack), .s_wr_en(s_wr_en),
        .s_bytesel(s_bytesel), .grant(grant)
    );

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m_addr(m_addr), .m_data_out(m_data_out), .m_data_in(fp_unused_data_in),
        .m_access(m_access), .m_ack(m_ack_fp), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .m_lock(m_lock),
        .s_addr(fp_unused_addr), .s_data_out(fp_unused_data_out), .s_data_in(s_data_in),
        .s_access(s_access_fp), .s_ack(s_ack), .s_wr_en(fp_unused_wr_en),
        .s_bytesel(fp_unused_bytesel), .grant(grant_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        m_access   = '0;
        m_wr_en    = '0;
        m_lock     = '0;
        s_ack      = 1'b0;
        s_data_in  = '0;
        m_addr     = {19'h00200, 19'h00100};
        m_data_out = {16'h2222, 16'h1111};
        m_bytesel  = {2'b01, 2'b11};

        // Reset state
        tick(); tick();
        s_ack = 1'b1;
        #1;
        check("rst_s_access", 64'(s_access), 64'h0);
        check("rst_m_ack",    64'(m_ack),    64'h0);
        check("rst_grant",    64'(grant),    64'h0);
        s_ack = 1'b0;

        // Round-robin with both masters requesting: 0, 1, 0
        reset    = 1'b1;
        m_access = 2'b11;
        #1;
        check("rr_idle_s_access", 64'(s_access), 64'h0);
        tick();
        check("rr_g0_grant",    64'(grant),      64'h0);
        check("rr_g0_s_access", 64'(s_access),   64'h1);
        check("rr_g0_s_addr",   64'(s_addr),     64'h00100);
        check("rr_g0_s_data",   64'(s_data_out), 64'h1111);
        s_ack = 1'b1;
        #1;
        check("rr_g0_m_ack", 64'(m_ack), 64'h1);
        tick();
        s_ack = 1'b0;
        #1;
        check("rr_gap1_s_access", 64'(s_access), 64'h0);
        tick();
        check("rr_g1_grant",    64'(grant),    64'h1);
        check("rr_g1_s_access", 64'(s_access), 64'h1);
        check("rr_g1_s_addr",   64'(s_addr),   64'h00200);
        s_ack = 1'b1;
        #1;
        check("rr_g1_m_ack", 64'(m_ack), 64'h2);
        tick();
        s_ack = 1'b0;
        #1;
        check("rr_gap2_s_access", 64'(s_access), 64'h0);
        tick();
        check("rr_g0b_grant", 64'(grant), 64'h0);
        s_ack = 1'b1;
        tick();
        s_ack    = 1'b0;
        m_access = 2'b00;

        // Read by master 0 with byte enables, acked one cycle later
        m_addr[AW-1:0]    = 19'h12345;
        m_bytesel[BW-1:0] = 2'b10;
        m_wr_en           = 2'b00;
        m_access          = 2'b01;
        tick();
        check("rd_s_addr",    64'(s_addr),    64'h12345);
        check("rd_s_bytesel", 64'(s_bytesel), 64'h2);
        check("rd_s_wr_en",   64'(s_wr_en),   64'h0);
        check("rd_s_access",  64'(s_access),  64'h1);
        check("rd_no_ack",    64'(m_ack),     64'h0);
        tick();
        s_ack     = 1'b1;
        s_data_in = 16'hBEEF;
        #1;
        check("rd_m_ack",     64'(m_ack),     64'h1);
        check("rd_m_data_in", 64'(m_data_in), 64'hBEEF);
        tick();
        s_ack     = 1'b0;
        m_access  = 2'b00;
        s_data_in = 16'h1234;
        #1;
        check("idle_m_data_in", 64'(m_data_in), 64'h1234);

        // Abort by master 1 after two owned cycles; it stays next in order
        m_access = 2'b10;
        tick();
        check("ab_grant",    64'(grant),    64'h1);
        check("ab_s_access", 64'(s_access), 64'h1);
        tick();
        check("ab_no_ack", 64'(m_ack), 64'h0);
        m_access = 2'b00;
        #1;
        check("ab_drop_s_access", 64'(s_access), 64'h0);
        tick();
        m_access = 2'b11;
        #1;
        check("ab_idle_s_access", 64'(s_access), 64'h0);
        check("ab_idle_m_ack",    64'(m_ack),    64'h0);
        tick();
        check("ab_rr_next_grant", 64'(grant),    64'h1);
        check("ab_rr_s_access",   64'(s_access), 64'h1);

        // Reset in the middle of master 1's transaction
        reset = 1'b0;
        s_ack = 1'b1;
        #1;
        check("mid_rst_m_ack", 64'(m_ack), 64'h0);
        tick();
        check("mid_rst_s_access", 64'(s_access), 64'h0);
        check("mid_rst_grant",    64'(grant),    64'h0);
        check("mid_rst_m_ack2",   64'(m_ack),    64'h0);
        reset    = 1'b1;
        s_ack    = 1'b0;
        m_access = 2'b00;

        // Fixed priority: master 1 continuous, master 0 arrives mid-transaction
        m_access = 2'b10;
        tick();
        check("fp_g1_grant",    64'(grant_fp),    64'h1);
        check("fp_g1_s_access", 64'(s_access_fp), 64'h1);
        s_ack = 1'b1;
        #1;
        check("fp_g1_m_ack", 64'(m_ack_fp), 64'h2);
        tick();
        s_ack = 1'b0;
        tick();
        m_access = 2'b11;
        #1;
        check("fp_wait_grant", 64'(grant_fp), 64'h1);
        check("fp_wait_m_ack", 64'(m_ack_fp), 64'h0);
        tick();
        s_ack = 1'b1;
        #1;
        check("fp_g1b_m_ack", 64'(m_ack_fp), 64'h2);
        tick();
        s_ack = 1'b0;
        #1;
        check("fp_gap_s_access", 64'(s_access_fp), 64'h0);
        tick();
        check("fp_g0_grant", 64'(grant_fp), 64'h0);
        s_ack = 1'b1;
        tick();
        s_ack    = 1'b0;
        m_access = 2'b00;

        // Master 1 locked read then write while master 0 requests
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        m_lock   = 2'b10;
        m_wr_en  = 2'b00;
        m_access = 2'b10;
        tick();
        check("lk_grant", 64'(grant), 64'h1);
        m_access = 2'b11;
        s_ack    = 1'b1;
        #1;
        check("lk_rd_m_ack", 64'(m_ack), 64'h2);
        tick();
        s_ack = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
        m_wr_en = 2'b10;
        m_lock  = 2'b00;
        #1;
        check("lk_b2b_s_access", 64'(s_access), 64'h1);
        check("lk_b2b_grant",    64'(grant),    64'h1);
        check("lk_b2b_s_wr_en",  64'(s_wr_en),  64'h1);
        s_ack = 1'b1;
        #1;
        check("lk_wr_m_ack", 64'(m_ack), 64'h2);
        tick();
        s_ack    = 1'b0;
        m_access = 2'b01;
        #1;
        check("lk_release_s_access", 64'(s_access), 64'h0);
`else
        #1;
        check("nolk_gap_s_access", 64'(s_access), 64'h0);
`endif
        tick();
        check("lk_next_grant",    64'(grant),    64'h0);
        check("lk_next_s_access", 64'(s_access), 64'h1);
        m_access = 2'b00;
        m_lock   = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
